// File: rtl/reset_sequencer.sv
// Reset sequencer: qualifies a debounced reset button and a PLL lock, then
// releases N_STAGE active-low domain resets one at a time, waiting for each
// domain's done flag before moving on. A done wait that runs out parks the
// sequencer in FAULT until the button is pressed and released again.
//
// Ports:
//   clk         - single clock for all logic
//   rst         - asynchronous active-high reset
//   key_n       - raw asynchronous reset button, 0 = pressed
//   pll_lock    - asynchronous PLL lock indication
//   stage_done  - per-stage ready flag, bit k sampled only while waiting on stage k
//   rstn_out    - per-domain active-low resets, bit 0 released first
//   busy        - high while any domain is held in reset, except in FAULT
//   timeout_err - sticky: a done wait expired
//   fault_stage - index of the stage whose done wait expired
module reset_sequencer #(
  parameter int unsigned N_STAGE      = 3,
  parameter int unsigned DEB_CYCLES   = 1000,
  parameter int unsigned STAGE_DLY    = 16,
  parameter int unsigned DONE_TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_n,
  input  logic               pll_lock,
  input  logic [N_STAGE-1:0] stage_done,
  output logic [N_STAGE-1:0] rstn_out,
  output logic               busy,
  output logic               timeout_err,
  output logic [2:0]         fault_stage
);

  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int unsigned DLY_W = $clog2(STAGE_DLY + 1);
  localparam int unsigned TO_W  = $clog2(DONE_TIMEOUT + 1);
  localparam int unsigned K_W   = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(STAGE_DLY - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(DONE_TIMEOUT - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(N_STAGE - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_DELAY     = 3'd1;
  localparam logic [2:0] ST_WAIT_DONE = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAULT     = 3'd4;

  logic             key_s1, key_s2, lock_s1, lock_s2;
  logic             deb_q;
  logic [DEB_W-1:0] deb_cnt_q;
  logic             qualified;

  logic [2:0]         state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [DLY_W-1:0]   dly_cnt_q, dly_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               press_seen_q, press_seen_d;
  logic [N_STAGE-1:0] rstn_q, rstn_d;
  logic               busy_q, busy_d;
  logic               terr_q, terr_d;
  logic [2:0]         fstage_q, fstage_d;

  // Two-flop synchronisers for both asynchronous inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1  <= 1'b0;
      key_s2  <= 1'b0;
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      key_s1  <= key_n;
      key_s2  <= key_s1;
      lock_s1 <= pll_lock;
      lock_s2 <= lock_s1;
    end
  end

  // Debouncer: counts consecutive cycles where the synchronised key differs
  // from the accepted level; any agreement reloads the count. Resetting to 0
  // means the button must be seen released before the first sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
    end else if (key_s2 == deb_q) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      deb_q     <= key_s2;
      deb_cnt_q <= '0;
    end else begin
      deb_cnt_q <= deb_cnt_q + DEB_W'(1);
    end
  end

  assign qualified = deb_q & lock_s2;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    dly_cnt_d    = dly_cnt_q;
    to_cnt_d     = to_cnt_q;
    press_seen_d = press_seen_q;
    rstn_d       = rstn_q;
    terr_d       = terr_q;
    fstage_d     = fstage_q;

    case (state_q)
      ST_IDLE: begin
        rstn_d = '0;
        if (qualified) begin
          k_d       = '0;
          dly_cnt_d = '0;
          state_d   = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (!qualified) begin
          rstn_d  = '0;
          state_d = ST_IDLE;
        end else if (dly_cnt_q == DLY_LAST) begin
          rstn_d[k_q] = 1'b1;
          to_cnt_d    = '0;
          state_d     = ST_WAIT_DONE;
        end else begin
          dly_cnt_d = dly_cnt_q + DLY_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!qualified) begin
          rstn_d  = '0;
          state_d = ST_IDLE;
        end else if (stage_done[k_q]) begin
          // Done is tested before expiry so a same-cycle tie goes to done.
          if (k_q == K_LAST) begin
            state_d = ST_RUN;
          end else begin
            k_d       = k_q + K_W'(1);
            dly_cnt_d = '0;
            state_d   = ST_DELAY;
          end
        end else if (to_cnt_q == TO_LAST) begin
          terr_d       = 1'b1;
          fstage_d     = 3'(k_q);
          rstn_d       = '0;
          press_seen_d = 1'b0;
          state_d      = ST_FAULT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_RUN: begin
        if (!qualified) begin
          rstn_d  = '0;
          state_d = ST_IDLE;
        end else begin
          rstn_d = '1;
        end
      end
      ST_FAULT: begin
        rstn_d = '0;
        // Leave only on a full press-then-release of the debounced key.
        if (!deb_q) begin
          press_seen_d = 1'b1;
        end else if (press_seen_q) begin
          press_seen_d = 1'b0;
          terr_d       = 1'b0;
          fstage_d     = 3'd0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        rstn_d  = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Derived from next-state values so busy lines up with the registered resets.
    busy_d = (rstn_d != '1) && (state_d != ST_FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      dly_cnt_q    <= '0;
      to_cnt_q     <= '0;
      press_seen_q <= 1'b0;
      rstn_q       <= '0;
      busy_q       <= 1'b1;
      terr_q       <= 1'b0;
      fstage_q     <= 3'd0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      dly_cnt_q    <= dly_cnt_d;
      to_cnt_q     <= to_cnt_d;
      press_seen_q <= press_seen_d;
      rstn_q       <= rstn_d;
      busy_q       <= busy_d;
      terr_q       <= terr_d;
      fstage_q     <= fstage_d;
    end
  end

  assign rstn_out    = rstn_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
  assign fault_stage = fstage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  localparam int unsigned N_STAGE      = 3;
  localparam int unsigned DEB_CYCLES   = 8;
  localparam int unsigned STAGE_DLY    = 4;
  localparam int unsigned DONE_TIMEOUT = 20;

  // Expected latencies in clocks, from the input change to the rstn_out change.
  localparam int FIRST_LAT = 2 + DEB_CYCLES + 1 + STAGE_DLY;     // key release to bit 0
  localparam int STEP_LAT  = 1 + STAGE_DLY;                      // done wait + delay
  localparam int LOCK_LAT  = 2 + 1 + STAGE_DLY;                  // lock return to bit 0
  localparam int FAULT_LAT = 2 + DEB_CYCLES + 1 + 1 + STAGE_DLY; // release out of FAULT

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               key_n = 1'b1;
  logic               pll_lock = 1'b1;
  logic [N_STAGE-1:0] stage_done = '1;
  logic [N_STAGE-1:0] rstn_out;
  logic               busy;
  logic               timeout_err;
  logic [2:0]         fault_stage;

  int checks = 0;
  int errors = 0;
  logic [N_STAGE-1:0] sb_q[$];
  logic [N_STAGE-1:0] model_rstn = '0;
  logic [N_STAGE-1:0] prev_rstn = '0;
  int n;

  reset_sequencer #(
    .N_STAGE      (N_STAGE),
    .DEB_CYCLES   (DEB_CYCLES),
    .STAGE_DLY    (STAGE_DLY),
    .DONE_TIMEOUT (DONE_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_n),
    .pll_lock    (pll_lock),
    .stage_done  (stage_done),
    .rstn_out    (rstn_out),
    .busy        (busy),
    .timeout_err (timeout_err),
    .fault_stage (fault_stage)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [N_STAGE-1:0] v);
    sb_q.push_back(v);
    model_rstn = v;
  endtask

  task automatic cycles(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic wait_for(input logic [N_STAGE-1:0] val, input int budget, input string tag,
                          output int cnt);
    cnt = 0;
    while (rstn_out !== val && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    if (rstn_out !== val) check_val(tag, rstn_out, val);
  endtask

  task automatic do_reset();
    if (model_rstn != '0) push('0);
    #2 rst = 1'b1;
    cycles(3);
    rst = 1'b0;
  endtask

  // Scoreboard: every change on rstn_out must match the next queued value,
  // and every observed value must be a contiguous run of ones from bit 0.
  always @(negedge clk) begin
    logic [N_STAGE-1:0] exp_v;
    logic [N_STAGE-1:0] inc;
    if (rstn_out !== prev_rstn) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected", rstn_out, prev_rstn);
      end else begin
        exp_v = sb_q.pop_front();
        check_val("sb_rstn", rstn_out, exp_v);
      end
      inc = rstn_out + 1'b1;
      check_val("monotonic", ((inc & rstn_out) == '0), 1);
      prev_rstn = rstn_out;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, sampled while rst is still held.
    #1 rst = 1'b1;
    #1;
    check_val("rst_rstn", rstn_out, 0);
    check_val("rst_busy", busy, 1);
    check_val("rst_terr", timeout_err, 0);
    check_val("rst_fstage", fault_stage, 0);

    // Normal bring-up with every done flag already high.
    push(3'b001); push(3'b011); push(3'b111);
    cycles(2);
    rst = 1'b0;
    wait_for(3'b001, 60, "seq_tmo0", n);
    check_val("seq_first_lat", n, FIRST_LAT);
    wait_for(3'b011, 30, "seq_tmo1", n);
    check_val("seq_step1_lat", n, STEP_LAT);
    wait_for(3'b111, 30, "seq_tmo2", n);
    check_val("seq_step2_lat", n, STEP_LAT);
    cycles(1);
    check_val("run_busy", busy, 0);
    check_val("run_terr", timeout_err, 0);
    cycles(3);

    // Lock loss in RUN drops every domain together, then re-sequences.
    push(3'b000);
    pll_lock = 1'b0;
    wait_for(3'b000, 10, "lock_tmo", n);
    check_val("lock_drop_lat", n, 3);
    check_val("lock_drop_busy", busy, 1);
    push(3'b001); push(3'b011); push(3'b111);
    pll_lock = 1'b1;
    wait_for(3'b001, 30, "relock_tmo0", n);
    check_val("relock_lat", n, LOCK_LAT);
    wait_for(3'b111, 30, "relock_tmo2", n);
    cycles(2);

    // Bouncing key must never release anything.
    key_n = 1'b0;
    do_reset();
    for (int i = 0; i < 50; i++) begin
      key_n = (i % 3 != 2);
      @(negedge clk);
    end
    key_n = 1'b0;
    cycles(4);
    check_val("bounce_hold", rstn_out, 0);
    push(3'b001); push(3'b011); push(3'b111);
    key_n = 1'b1;
    wait_for(3'b001, 60, "bounce_tmo0", n);
    check_val("bounce_lat", n, FIRST_LAT);
    wait_for(3'b111, 30, "bounce_tmo2", n);
    cycles(2);

    // Stage 1 never reports done: timeout, FAULT, then press/release recovery.
    do_reset();
    stage_done = 3'b101;
    push(3'b001); push(3'b011); push(3'b000);
    wait_for(3'b011, 80, "to_tmo1", n);
    wait_for(3'b000, 40, "to_tmo_fault", n);
    check_val("to_lat", n, DONE_TIMEOUT);
    check_val("to_terr", timeout_err, 1);
    check_val("to_fstage", fault_stage, 1);
    check_val("to_busy", busy, 0);
    cycles(30);
    check_val("fault_hold_rel", timeout_err, 1);
    key_n = 1'b0;
    cycles(15);
    check_val("fault_hold_press", timeout_err, 1);
    check_val("fault_hold_busy", busy, 0);
    stage_done = 3'b111;
    push(3'b001); push(3'b011); push(3'b111);
    key_n = 1'b1;
    wait_for(3'b001, 60, "fault_exit_tmo", n);
    check_val("fault_exit_lat", n, FAULT_LAT);
    check_val("fault_clr_terr", timeout_err, 0);
    check_val("fault_clr_fstage", fault_stage, 0);
    wait_for(3'b111, 30, "fault_exit_tmo2", n);
    cycles(2);

    // Last done arrives on the exact expiry cycle: done wins.
    do_reset();
    stage_done = 3'b011;
    push(3'b001); push(3'b011); push(3'b111);
    wait_for(3'b111, 80, "tie_tmo", n);
    cycles(DONE_TIMEOUT - 1);
    stage_done = 3'b111;
    cycles(1);
    check_val("tie_terr", timeout_err, 0);
    cycles(5);
    check_val("tie_terr_late", timeout_err, 0);
    check_val("tie_rstn", rstn_out, 3'b111);
    check_val("tie_busy", busy, 0);

    // Asynchronous reset in the middle of the stage-1 done wait.
    do_reset();
    stage_done = 3'b101;
    push(3'b001); push(3'b011);
    wait_for(3'b011, 80, "arst_tmo", n);
    cycles(3);
    push(3'b000);
    #2 rst = 1'b1;
    #1;
    check_val("arst_rstn", rstn_out, 0);
    check_val("arst_busy", busy, 1);
    cycles(2);
    rst = 1'b0;
    stage_done = 3'b111;
    push(3'b001); push(3'b011); push(3'b111);
    wait_for(3'b001, 60, "arst_re_tmo", n);
    check_val("arst_re_lat", n, FIRST_LAT);
    wait_for(3'b111, 30, "arst_re_tmo2", n);
    cycles(5);

    check_val("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter N_STAGE, default 3, number of sequenced reset domains (1..8).
REQ-002 SHALL have parameter DEB_CYCLES, default 1000, consecutive stable cycles the debouncer needs to accept a new key level (>=2).
REQ-003 SHALL have parameter STAGE_DLY, default 16, cycles between qualifying a stage and releasing its reset (>=1).
REQ-004 SHALL have parameter DONE_TIMEOUT, default 65535, maximum cycles spent waiting for a stage's done (>=1).
REQ-005 SHALL have port clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port key_n, input, 1, raw asynchronous reset button (0 = pressed).
REQ-008 SHALL have port pll_lock, input, 1, asynchronous PLL lock indication.
REQ-009 SHALL have port stage_done, input, N_STAGE, per-stage ready flag; bit k is sampled only while waiting on stage k.
REQ-010 SHALL have port rstn_out, output, N_STAGE, per-domain active-low reset (bit 0 released first).
REQ-011 SHALL have port busy, output, 1, high whenever any rstn_out bit is low and the FSM is not in FAULT.
REQ-012 SHALL have port timeout_err, output, 1, sticky flag: a stage_done wait expired.
REQ-013 SHALL have port fault_stage, output, 3, index of the stage that timed out.

Function
REQ-014 SHALL pass key_n and pll_lock each through a 2-flop synchroniser before any other use.
REQ-015 SHALL debounce synchronised key_n: the output level changes only after the input differs from it for DEB_CYCLES consecutive cycles; any bounce reloads the counter to 0.
REQ-016 SHALL NOT debounce pll_lock; the synchronised value is used directly.
REQ-017 SHALL define "qualified" as debounced key released (1) AND synchronised pll_lock = 1.
REQ-018 SHALL implement the states IDLE, DELAY, WAIT_DONE, RUN and FAULT, with a stage index k.
REQ-019 IDLE: all rstn_out = 0; when qualified, set k = 0, load the delay counter and go to DELAY.
REQ-020 DELAY: count STAGE_DLY cycles, then set rstn_out[k] = 1 and go to WAIT_DONE, loading the timeout counter.
REQ-021 WAIT_DONE: if stage_done[k] = 1 and k = N_STAGE-1, go to RUN; if stage_done[k] = 1 and k < N_STAGE-1, increment k and go to DELAY; if DONE_TIMEOUT cycles elapse, set timeout_err, set fault_stage = k and go to FAULT.
REQ-022 If stage_done[k] and timeout expiry occur in the same cycle, done SHALL win.
REQ-023 RUN: all rstn_out = 1 and busy = 0.
REQ-024 In DELAY, WAIT_DONE or RUN, loss of qualification SHALL drive every rstn_out to 0 on the next clock edge (all bits in the same cycle) and return the FSM to IDLE. This takes priority over any other transition.
REQ-025 FAULT: all rstn_out = 0 and busy = 0. Only a debounced key press followed by a debounced release SHALL leave FAULT; it returns to IDLE and clears timeout_err and fault_stage.
REQ-026 Released stages SHALL stay released while later stages are sequenced; rstn_out is monotonic (bit j = 1 implies bit j-1 = 1).
REQ-027 Counter widths SHALL be clog2(max+1) of their parameter; counters SHALL saturate and never wrap.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 On rst: state = IDLE, rstn_out = 0, busy = 1, timeout_err = 0, fault_stage = 0, k = 0, all counters = 0.
REQ-030 The debounced key level SHALL reset to 0 (pressed), so it must see DEB_CYCLES of key_n = 1 before the first release.
REQ-031 rst asserted mid-sequence SHALL force the REQ-029 values asynchronously, without waiting for a clock edge.

Verification (N_STAGE=3, DEB_CYCLES=8, STAGE_DLY=4, DONE_TIMEOUT=20)
REQ-032 Stimulus: key_n = 1, lock = 1, stage_done = 111 after rst. Response: rstn_out goes 000 -> 001 -> 011 -> 111; each step is 4 cycles plus the sampling latency; busy = 0 in RUN.
REQ-033 Stimulus: key_n bounces with a period of 3 cycles for 50 cycles, then holds at 1. Response: rstn_out stays 000 until 8 stable cycles plus the synchroniser latency.
REQ-034 Stimulus: pll_lock drops while in RUN. Response: rstn_out = 000 within 3 cycles (2 synchroniser + 1), in a single cycle; it re-sequences when lock returns.
REQ-035 Stimulus: stage_done[1] is held at 0. Response: after 20 WAIT_DONE cycles, timeout_err = 1, fault_stage = 1, rstn_out = 000; a debounced press and release clears both flags and restarts the sequence.
REQ-036 Stimulus: stage_done[2] rises on the exact cycle the timeout expires. Response: RUN is reached and timeout_err stays 0.
REQ-037 Stimulus: rst pulses while in WAIT_DONE at k = 1. Response: rstn_out = 000 immediately and the FSM restarts from IDLE.
